// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the cartridge ROM port arbiter.
// The optional statistics block is enabled with the ROM_ARB_STATS_EN macro
// (see rom_port_arbiter).
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int MAX_NREQ = 8;

    // Byte lane select for byte reads: odd addresses take the high lane.
    function automatic logic [7:0] byte_sel(input logic addr0, input logic [15:0] q);
        return addr0 ? q[15:8] : q[7:0];
    endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational grant picker for the ROM port arbiter.
// Order: lowest starving secondary, then requester 0, then round-robin over
// the secondaries starting at the pointer.
module rom_arb_pick
    import rom_arb_pkg::*;
#(
    parameter int NREQ = 3,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [NREQ-1:0] starved,
    input  logic [IW-1:0]   pointer,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index,
    output logic            any
);

    // Walk the three priority tiers; the first hit wins.
    always_comb begin
        logic found;
        int   cand;
        found = 1'b0;
        cand  = 0;
        index = '0;
        grant = '0;
        for (int i = 1; i < NREQ; i++) begin
            if (!found && valid[i] && starved[i]) begin
                found = 1'b1;
                index = IW'(i);
            end
        end
        if (!found && valid[0]) begin
            found = 1'b1;
            index = '0;
        end
        for (int k = 0; k < NREQ - 1; k++) begin
            // Secondaries live in 1..NREQ-1, so wrap back to 1, never to 0.
            cand = int'(pointer) + k;
            if (cand >= NREQ) begin
                cand = cand - (NREQ - 1);
            end
            if (!found && valid[cand]) begin
                found = 1'b1;
                index = IW'(cand);
            end
        end
        any = found;
        if (found) begin
            grant[index] = 1'b1;
        end
    end

    // Keep the parameter range honest at elaboration.
    if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
        $error("rom_arb_pick: NREQ out of range");
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one cartridge ROM port between NREQ read requesters, one access at
// a time, with starvation protection for the secondary requesters and an
// ack timeout on the ROM controller.
// Optional feature: define ROM_ARB_STATS_EN to add grant/timeout counters.
//
// state | meaning
// IDLE  | no access in flight; grant any pending requester this cycle
// ISSUE | mem_req high, waiting for mem_ack or timeout
// RESP  | one-cycle response strobe to the granted requester
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int AW           = 24,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 15,
    parameter int TIMEOUT      = 1023
) (
    input  logic               mclk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]    req_word,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic               mem_req,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_word,
    input  logic               mem_ack,
    input  logic [DW-1:0]      mem_q
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0] stat_grants,
    output logic [15:0]        stat_timeouts
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_nx;

    logic [NREQ-1:0]   pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [NREQ-1:0]   starved;
    logic [IW-1:0]     rr_ptr;
    logic [SW-1:0]     starve [NREQ];

    logic [NREQ-1:0]   gnt_oh;
    logic [AW-1:0]     addr_q;
    logic              word_q;
    logic [DW-1:0]     data_q;
    logic              err_q;
    logic [TW-1:0]     tmo_cnt;
    logic              grant_now;
    logic              timeout_hit;

    rom_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .valid   (req_valid),
        .starved (starved),
        .pointer (rr_ptr),
        .grant   (pick_grant),
        .index   (pick_idx),
        .any     (pick_any)
    );

    assign grant_now   = (state == IDLE) && pick_any;
    assign timeout_hit = (state == ISSUE) && !mem_ack && (tmo_cnt == '0);

    // A starving requester is one whose counter has saturated.
    always_comb begin
        starved = '0;
        for (int i = 1; i < NREQ; i++) begin
            starved[i] = (starve[i] == SW'(STARVE_LIMIT));
        end
    end

    // State register.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: ack wins over a timeout landing in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_any) state_nx = ISSUE;
            ISSUE:   if (mem_ack || tmo_cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; accept pulse is combinational so it lands in the grant cycle.
    always_comb begin
        req_ready = grant_now ? pick_grant : '0;
        rsp_valid = (state == RESP) ? gnt_oh : '0;
        rsp_err   = (state == RESP) && err_q;
        rsp_data  = data_q;
        mem_addr  = addr_q;
        mem_word  = word_q;
    end

    // Access datapath: latch the granted request, run the timeout down-counter, capture data.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            mem_req <= 1'b0;
            gnt_oh  <= '0;
            addr_q  <= '0;
            word_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            mem_req <= (state_nx == ISSUE);
            if (grant_now) begin
                gnt_oh  <= pick_grant;
                addr_q  <= req_addr[int'(pick_idx)*AW +: AW];
                word_q  <= req_word[pick_idx];
                err_q   <= 1'b0;
                tmo_cnt <= TW'(TIMEOUT - 1);
            end else if (state == ISSUE) begin
                if (mem_ack) begin
                    data_q <= word_q ? mem_q
                                     : {{(DW-8){1'b0}}, byte_sel(addr_q[0], mem_q[15:0])};
                end else if (timeout_hit) begin
                    data_q <= '1;
                    err_q  <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt - TW'(1);
                end
            end
        end
    end

    // Round-robin pointer advances past each secondary grant, skipping requester 0.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            rr_ptr <= IW'(1);
        end else if (grant_now && pick_idx != '0) begin
            rr_ptr <= (int'(pick_idx) == NREQ - 1) ? IW'(1) : pick_idx + IW'(1);
        end
    end

    // Starve counters: count ungranted pending cycles, clear on grant or withdrawal.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                starve[i] <= '0;
            end
        end else begin
            starve[0] <= '0;
            for (int i = 1; i < NREQ; i++) begin
                if (!req_valid[i] || req_ready[i]) begin
                    starve[i] <= '0;
                end else if (starve[i] != SW'(STARVE_LIMIT)) begin
                    starve[i] <= starve[i] + SW'(1);
                end
            end
        end
    end

`ifdef ROM_ARB_STATS_EN
    // Saturating per-requester grant counters and timeout counter.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            stat_grants   <= '0;
            stat_timeouts <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && stat_grants[i*16 +: 16] != 16'hFFFF) begin
                    stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
                end
            end
            if (timeout_hit && stat_timeouts != 16'hFFFF) begin
                stat_timeouts <= stat_timeouts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter (NREQ=3, AW=24, DW=16, default limits).
module tb_rom_port_arbiter;

    logic        mclk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [71:0] req_addr;
    logic [2:0]  req_word;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_word;
    logic        mem_ack;
    logic [15:0] mem_q;
`ifdef ROM_ARB_STATS_EN
    logic [47:0] stat_grants;
    logic [15:0] stat_timeouts;
`endif

    logic auto_ack;
    logic manual_ack;
    int   checks;
    int   errors;

    rom_port_arbiter dut (
        .mclk      (mclk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_word  (req_word),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_word  (mem_word),
        .mem_ack   (mem_ack),
        .mem_q     (mem_q)
`ifdef ROM_ARB_STATS_EN
        ,
        .stat_grants   (stat_grants),
        .stat_timeouts (stat_timeouts)
`endif
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // ROM model: acks in the first cycle mem_req is seen high, or on demand.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge mclk);
            #2;
            mem_ack = (auto_ack && mem_req) || manual_ack;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated read by requester r with immediate ack.
    task automatic single_read(input int r, input logic [23:0] a, input logic w,
                               input logic [15:0] q, input logic [15:0] exp_data);
        logic [2:0] oh;
        oh = 3'b001 << r;
        @(posedge mclk); #1;
        req_valid = oh;
        req_addr[r*24 +: 24] = a;
        req_word[r] = w;
        mem_q = q;
        auto_ack = 1'b1;
        @(negedge mclk);
        chk("grant_ready", {61'd0, req_ready}, {61'd0, oh});
        @(posedge mclk); #1;
        req_valid = 3'b000;
        @(negedge mclk);
        chk("issue_mem_req", {63'd0, mem_req}, 64'd1);
        chk("issue_mem_addr", {40'd0, mem_addr}, {40'd0, a});
        chk("issue_mem_word", {63'd0, mem_word}, {63'd0, w});
        chk("issue_no_rsp", {61'd0, rsp_valid}, 64'd0);
        @(negedge mclk);
        chk("resp_valid", {61'd0, rsp_valid}, {61'd0, oh});
        chk("resp_data", {48'd0, rsp_data}, {48'd0, exp_data});
        chk("resp_err", {63'd0, rsp_err}, 64'd0);
        chk("resp_mem_req_low", {63'd0, mem_req}, 64'd0);
    endtask

    initial begin
        logic [2:0] exp_rr [4];
        int  n;
        int  n0;
        int  hi;
        logic got1;
        logic done;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_word = '0;
        mem_q = '0;
        auto_ack = 1'b0;
        manual_ack = 1'b0;

        // Reset state.
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_rsp_valid", {61'd0, rsp_valid}, 64'd0);
        chk("rst_req_ready", {61'd0, req_ready}, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("rst_mem_addr", {40'd0, mem_addr}, 64'd0);
        chk("rst_rsp_data", {48'd0, rsp_data}, 64'd0);
        @(posedge mclk); #1;
        rst = 1'b0;

        // Word read, byte reads on both lanes, and a secondary word read.
        single_read(0, 24'h00_8000, 1'b1, 16'hBEEF, 16'hBEEF);
        single_read(0, 24'h00_0001, 1'b0, 16'h12AB, 16'h0012);
        single_read(0, 24'h00_0002, 1'b0, 16'h12AB, 16'h00AB);
        single_read(2, 24'hFF_FFFE, 1'b1, 16'h5A5A, 16'h5A5A);

        // Round-robin between requesters 1 and 2.
        exp_rr[0] = 3'b010;
        exp_rr[1] = 3'b100;
        exp_rr[2] = 3'b010;
        exp_rr[3] = 3'b100;
        @(posedge mclk); #1;
        req_addr[24 +: 24] = 24'h01_0000;
        req_addr[48 +: 24] = 24'h02_0000;
        req_word = 3'b111;
        mem_q = 16'h7777;
        req_valid = 3'b110;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge mclk);
                n++;
            end while (req_ready == 3'b000 && n < 20);
            chk("rr_grant", {61'd0, req_ready}, {61'd0, exp_rr[k]});
        end
        @(posedge mclk); #1;
        req_valid = 3'b000;
        repeat (4) @(posedge mclk);
        #1;

        // Requester 0 hogging; requester 1 wins after 15 waiting cycles.
        req_valid = 3'b011;
        n0 = 0;
        got1 = 1'b0;
        for (int c = 0; c < 60 && !got1; c++) begin
            @(negedge mclk);
            if (req_ready == 3'b001) n0++;
            else if (req_ready == 3'b010) got1 = 1'b1;
        end
        chk("starve_grant_seen", {63'd0, got1}, 64'd1);
        chk("starve_req0_grants", 64'(n0), 64'd5);
        @(posedge mclk); #1;
        req_valid = 3'b000;
        repeat (4) @(posedge mclk);
        #1;

        // Timeout: no ack ever.
        auto_ack = 1'b0;
        req_addr[23:0] = 24'h12_3456;
        req_word = 3'b001;
        req_valid = 3'b001;
        @(negedge mclk);
        chk("tmo_ready", {61'd0, req_ready}, 64'd1);
        @(posedge mclk); #1;
        req_valid = 3'b000;
        hi = 0;
        done = 1'b0;
        for (int c = 0; c < 1100 && !done; c++) begin
            @(negedge mclk);
            if (mem_req) hi++;
            else done = 1'b1;
        end
        chk("tmo_mem_req_cycles", 64'(hi), 64'd1023);
        chk("tmo_rsp_valid", {61'd0, rsp_valid}, 64'd1);
        chk("tmo_rsp_err", {63'd0, rsp_err}, 64'd1);
        chk("tmo_rsp_data", {48'd0, rsp_data}, 64'h0000_0000_0000_FFFF);
        // Late ack in IDLE must be ignored.
        @(posedge mclk); #1;
        manual_ack = 1'b1;
        @(negedge mclk);
        chk("late_ack_no_rsp", {61'd0, rsp_valid}, 64'd0);
        @(posedge mclk); #1;
        manual_ack = 1'b0;
        @(negedge mclk);
        chk("late_ack_no_rsp2", {61'd0, rsp_valid}, 64'd0);
        chk("late_ack_no_req", {63'd0, mem_req}, 64'd0);

        // Reset in the middle of ISSUE.
        @(posedge mclk); #1;
        req_addr[23:0] = 24'h00_4242;
        req_valid = 3'b001;
        @(negedge mclk);
        chk("rst_mid_ready", {61'd0, req_ready}, 64'd1);
        @(posedge mclk); #1;
        req_valid = 3'b000;
        @(negedge mclk);
        chk("rst_mid_issue", {63'd0, mem_req}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mid_rsp_valid", {61'd0, rsp_valid}, 64'd0);
        @(posedge mclk); #1;
        rst = 1'b0;
        manual_ack = 1'b1;
        @(posedge mclk); #1;
        manual_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge mclk);
            chk("post_rst_no_rsp", {61'd0, rsp_valid}, 64'd0);
        end
`ifdef ROM_ARB_STATS_EN
        chk("stat_grants_clr", {16'd0, stat_grants}, 64'd0);
        chk("stat_timeouts_clr", {48'd0, stat_timeouts}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
